// File: rtl/adc_sample_scheduler.sv
// adc_sample_scheduler
//   Sample-rate controller for the SPI ADC master. A free-running divider
//   produces a periodic tick; each tick launches one SPI conversion whose
//   result is offered to the equalizer filter chain over a valid/ack
//   handshake. Sticky flags report overruns, late ticks and (optionally)
//   watchdog aborts.
//
//   Optional feature: define ADC_TIMEOUT_EN to build a watchdog that aborts
//   a conversion after TIMEOUT_CYC cycles in CONVERT. Without it CONVERT
//   waits indefinitely and timeout_err is tied low.
module adc_sample_scheduler #(
    parameter int DATA_W      = 16,
    parameter int CLK_DIV     = 2267,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              clr_flags,
    output logic              spi_start,
    input  logic              spi_busy,
    input  logic              spi_ready,
    input  logic [DATA_W-1:0] spi_data,
    output logic [DATA_W-1:0] sample_data,
    output logic              sample_valid,
    input  logic              sample_ack,
    output logic              overrun,
    output logic              late,
    output logic              timeout_err,
    output logic [15:0]       sample_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_TICK = 2'd1,
        ST_START     = 2'd2,
        ST_CONVERT   = 2'd3
    } state_t;

    localparam logic [15:0] TICK_LAST = 16'(CLK_DIV - 1);

    logic [15:0]       tick_cnt_r;
    logic              tick_s;
    state_t            state_r;
    state_t            state_nxt_s;
    logic              capture_s;
    logic              timeout_hit_s;
    logic              spi_start_r;
    logic [DATA_W-1:0] sample_data_r;
    logic              sample_valid_r;
    logic [15:0]       sample_cnt_r;
    logic              overrun_r;
    logic              late_r;

    // spi_busy is informational only; TIMEOUT_CYC is only consumed by the
    // optional watchdog. Both are folded into a deliberately unused sink.
    logic              unused_s;
    assign unused_s = ^{spi_busy, 16'(TIMEOUT_CYC)};

    // Sample-rate divider: counts 0..CLK_DIV-1 while enabled, held at 0 otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_r <= 16'd0;
        end else if (!enable) begin
            tick_cnt_r <= 16'd0;
        end else if (tick_cnt_r == TICK_LAST) begin
            tick_cnt_r <= 16'd0;
        end else begin
            tick_cnt_r <= tick_cnt_r + 16'd1;
        end
    end

    assign tick_s = enable & (tick_cnt_r == TICK_LAST);

`ifdef ADC_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);

    logic [15:0] wd_cnt_r;
    logic        abort_s;
    logic        timeout_err_r;

    // Watchdog: counts cycles spent in CONVERT, restarts on every entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_r <= 16'd0;
        end else if (state_r == ST_CONVERT) begin
            wd_cnt_r <= wd_cnt_r + 16'd1;
        end else begin
            wd_cnt_r <= 16'd0;
        end
    end

    assign timeout_hit_s = (state_r == ST_CONVERT) & (wd_cnt_r == TIMEOUT_LAST);
    // A spi_ready in the timeout cycle wins and is captured normally.
    assign abort_s       = timeout_hit_s & ~spi_ready;

    // Sticky watchdog-abort flag; a new abort outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_err_r <= 1'b0;
        end else if (abort_s) begin
            timeout_err_r <= 1'b1;
        end else if (clr_flags) begin
            timeout_err_r <= 1'b0;
        end else begin
            timeout_err_r <= timeout_err_r;
        end
    end

    assign timeout_err = timeout_err_r;
`else
    assign timeout_hit_s = 1'b0;
    assign timeout_err   = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state and capture decision.
    always_comb begin
        state_nxt_s = state_r;
        capture_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    state_nxt_s = ST_WAIT_TICK;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT_TICK: begin
                if (!enable) begin
                    state_nxt_s = ST_IDLE;
                end else if (tick_s) begin
                    state_nxt_s = ST_START;
                end else begin
                    state_nxt_s = ST_WAIT_TICK;
                end
            end
            ST_START: begin
                state_nxt_s = ST_CONVERT;
            end
            ST_CONVERT: begin
                if (spi_ready) begin
                    capture_s   = 1'b1;
                    state_nxt_s = enable ? ST_WAIT_TICK : ST_IDLE;
                end else if (timeout_hit_s) begin
                    state_nxt_s = enable ? ST_WAIT_TICK : ST_IDLE;
                end else begin
                    state_nxt_s = ST_CONVERT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Registered start pulse: high exactly during the START cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            spi_start_r <= 1'b0;
        end else begin
            spi_start_r <= (state_nxt_s == ST_START);
        end
    end

    // Sample holding register and valid/ack handshake; a capture always loads.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_data_r  <= '0;
            sample_valid_r <= 1'b0;
            sample_cnt_r   <= 16'd0;
        end else if (capture_s) begin
            sample_data_r  <= spi_data;
            sample_valid_r <= 1'b1;
            sample_cnt_r   <= sample_cnt_r + 16'd1;
        end else if (sample_valid_r && sample_ack) begin
            sample_data_r  <= sample_data_r;
            sample_valid_r <= 1'b0;
            sample_cnt_r   <= sample_cnt_r;
        end else begin
            sample_data_r  <= sample_data_r;
            sample_valid_r <= sample_valid_r;
            sample_cnt_r   <= sample_cnt_r;
        end
    end

    // Sticky overrun: capture over an unacknowledged sample; set beats clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_r <= 1'b0;
        end else if (capture_s && sample_valid_r && !sample_ack) begin
            overrun_r <= 1'b1;
        end else if (clr_flags) begin
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    // Sticky late flag: a tick outside WAIT_TICK is dropped and recorded.
    always_ff @(posedge clk) begin
        if (rst) begin
            late_r <= 1'b0;
        end else if (tick_s && (state_r != ST_WAIT_TICK)) begin
            late_r <= 1'b1;
        end else if (clr_flags) begin
            late_r <= 1'b0;
        end else begin
            late_r <= late_r;
        end
    end

    assign spi_start    = spi_start_r;
    assign sample_data  = sample_data_r;
    assign sample_valid = sample_valid_r;
    assign sample_cnt   = sample_cnt_r;
    assign overrun      = overrun_r;
    assign late         = late_r;

endmodule
